cache_fm_ctrl: RTL and testbench



---
 rtl/cache_fm_ctrl.sv | 135 +++++++++++++
 tb/tb_cache_fm_ctrl.sv | 448 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_fm_ctrl.sv
// Far-memory controller: buffers fills and dirty evictions, issues them in order to a
// line-wide memory port, and pairs in-order read data with the requesting TQ id.
module cache_fm_ctrl #(
    parameter int REQ_DEPTH       = 4,
    parameter int MAX_OUTSTANDING = 8,
    localparam int RPW = $clog2(REQ_DEPTH),
    localparam int TPW = $clog2(MAX_OUTSTANDING)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           fm_req_valid,
    input  logic [2:0]     fm_req_tq_id,
    input  logic [19:0]    fm_req_address,
    input  logic [127:0]   fm_req_data,
    input  logic [1:0]     fm_req_opcode,
    output logic           fm_req_ready,
    output logic           mem_req_valid,
    input  logic           mem_req_ready,
    output logic           mem_req_wr,
    output logic [15:0]    mem_req_cl_addr,
    output logic [127:0]   mem_req_wdata,
    input  logic           mem_rsp_valid,
    input  logic [127:0]   mem_rsp_data,
    output logic           fm_rd_rsp_valid,
    output logic [2:0]     fm_rd_rsp_tq_id,
    output logic [127:0]   fm_rd_rsp_data,
    output logic [TPW:0]   outstanding_cnt,
    output logic           err_sticky
);

    typedef struct packed {
        logic         wr;
        logic [2:0]   tq;
        logic [15:0]  cl;
        logic [127:0] data;
    } req_t;

    req_t       req_mem [REQ_DEPTH];
    logic [2:0] tag_mem [MAX_OUTSTANDING];

    logic [RPW:0]   req_wr_ptr_q, req_wr_ptr_d, req_rd_ptr_q, req_rd_ptr_d;
    logic [TPW:0]   tag_wr_ptr_q, tag_wr_ptr_d, tag_rd_ptr_q, tag_rd_ptr_d;
    logic [TPW:0]   cnt_q, cnt_d;
    logic           err_q, err_d;
    logic           rsp_valid_q, rsp_valid_d;
    logic [2:0]     rsp_tq_q, rsp_tq_d;
    logic [127:0]   rsp_data_q, rsp_data_d;

    logic           req_empty, req_full, tag_empty, tag_full;
    logic           req_push, issue_valid, issue, rd_issue, rsp_hit;
    req_t           req_head, req_new;
    logic           unused_addr_bits;

    assign unused_addr_bits = ^fm_req_address[3:0];

    always_comb begin
        req_empty    = (req_wr_ptr_q == req_rd_ptr_q);
        req_full     = ((req_wr_ptr_q ^ req_rd_ptr_q) == {1'b1, {RPW{1'b0}}});
        tag_empty    = (tag_wr_ptr_q == tag_rd_ptr_q);
        tag_full     = ((tag_wr_ptr_q ^ tag_rd_ptr_q) == {1'b1, {TPW{1'b0}}});
        req_head     = req_mem[req_rd_ptr_q[RPW-1:0]];

        // opcode bit0 marks a real request (01 evict, 11 fill); bit1 clear means write
        req_push     = fm_req_valid & ~req_full & fm_req_opcode[0];
        req_new.wr   = ~fm_req_opcode[1];
        req_new.tq   = fm_req_tq_id;
        req_new.cl   = fm_req_address[19:4];
        req_new.data = fm_req_opcode[1] ? '0 : fm_req_data;

        // tag_full is the pre-pop view, so a same-cycle response cannot unblock a read
        issue_valid  = ~req_empty & (req_head.wr | ~tag_full);
        issue        = issue_valid & mem_req_ready;
        rd_issue     = issue & ~req_head.wr;
        rsp_hit      = mem_rsp_valid & ~tag_empty;

        req_wr_ptr_d = req_wr_ptr_q + {{RPW{1'b0}}, req_push};
        req_rd_ptr_d = req_rd_ptr_q + {{RPW{1'b0}}, issue};
        tag_wr_ptr_d = tag_wr_ptr_q + {{TPW{1'b0}}, rd_issue};
        tag_rd_ptr_d = tag_rd_ptr_q + {{TPW{1'b0}}, rsp_hit};

        cnt_d = cnt_q;
        case ({rd_issue, rsp_hit})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase

        err_d = err_q | (fm_req_valid & (fm_req_opcode == 2'b10)) | (mem_rsp_valid & tag_empty);

        rsp_valid_d = rsp_hit;
        rsp_tq_d    = rsp_hit ? tag_mem[tag_rd_ptr_q[TPW-1:0]] : rsp_tq_q;
        rsp_data_d  = rsp_hit ? mem_rsp_data : rsp_data_q;
    end

    always_ff @(posedge clk) begin
        if (req_push) req_mem[req_wr_ptr_q[RPW-1:0]] <= req_new;
        if (rd_issue) tag_mem[tag_wr_ptr_q[TPW-1:0]] <= req_head.tq;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_wr_ptr_q <= '0;
            req_rd_ptr_q <= '0;
            tag_wr_ptr_q <= '0;
            tag_rd_ptr_q <= '0;
            cnt_q        <= '0;
            err_q        <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_tq_q     <= '0;
            rsp_data_q   <= '0;
        end else begin
            req_wr_ptr_q <= req_wr_ptr_d;
            req_rd_ptr_q <= req_rd_ptr_d;
            tag_wr_ptr_q <= tag_wr_ptr_d;
            tag_rd_ptr_q <= tag_rd_ptr_d;
            cnt_q        <= cnt_d;
            err_q        <= err_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_tq_q     <= rsp_tq_d;
            rsp_data_q   <= rsp_data_d;
        end
    end

    assign fm_req_ready    = ~req_full;
    assign mem_req_valid   = issue_valid;
    assign mem_req_wr      = req_head.wr;
    assign mem_req_cl_addr = req_head.cl;
    assign mem_req_wdata   = req_head.wr ? req_head.data : '0;
    assign fm_rd_rsp_valid = rsp_valid_q;
    assign fm_rd_rsp_tq_id = rsp_tq_q;
    assign fm_rd_rsp_data  = rsp_data_q;
    assign outstanding_cnt = cnt_q;
    assign err_sticky      = err_q;

endmodule

// File: tb/tb_cache_fm_ctrl.sv
// Bench for cache_fm_ctrl: directed scenarios plus a randomized run checked against
// a queue-based model of the request buffer and outstanding reads.
module tb_cache_fm_ctrl;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         fm_req_valid = 1'b0;
    logic [2:0]   fm_req_tq_id = '0;
    logic [19:0]  fm_req_address = '0;
    logic [127:0] fm_req_data = '0;
    logic [1:0]   fm_req_opcode = '0;
    logic         fm_req_ready;
    logic         mem_req_valid;
    logic         mem_req_ready = 1'b0;
    logic         mem_req_wr;
    logic [15:0]  mem_req_cl_addr;
    logic [127:0] mem_req_wdata;
    logic         mem_rsp_valid = 1'b0;
    logic [127:0] mem_rsp_data = '0;
    logic         fm_rd_rsp_valid;
    logic [2:0]   fm_rd_rsp_tq_id;
    logic [127:0] fm_rd_rsp_data;
    logic [3:0]   outstanding_cnt;
    logic         err_sticky;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    cache_fm_ctrl #(.REQ_DEPTH(4), .MAX_OUTSTANDING(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .fm_req_valid(fm_req_valid), .fm_req_tq_id(fm_req_tq_id),
        .fm_req_address(fm_req_address), .fm_req_data(fm_req_data),
        .fm_req_opcode(fm_req_opcode), .fm_req_ready(fm_req_ready),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_wr(mem_req_wr), .mem_req_cl_addr(mem_req_cl_addr),
        .mem_req_wdata(mem_req_wdata), .mem_rsp_valid(mem_rsp_valid),
        .mem_rsp_data(mem_rsp_data), .fm_rd_rsp_valid(fm_rd_rsp_valid),
        .fm_rd_rsp_tq_id(fm_rd_rsp_tq_id), .fm_rd_rsp_data(fm_rd_rsp_data),
        .outstanding_cnt(outstanding_cnt), .err_sticky(err_sticky)
    );

    // reference model: pending requests, outstanding read tags, registered response
    typedef struct {
        bit         wr;
        bit [2:0]   tq;
        bit [15:0]  cl;
        bit [127:0] data;
    } mreq_t;

    mreq_t      m_req[$];
    bit [2:0]   m_tag[$];
    bit         m_rsp_v;
    bit [2:0]   m_rsp_tq;
    bit [127:0] m_rsp_data;
    bit         m_err;

    function automatic void model_clear();
        m_req.delete();
        m_tag.delete();
        m_rsp_v = 0;
        m_rsp_tq = 0;
        m_rsp_data = 0;
        m_err = 0;
    endfunction

    function automatic void model_edge();
        bit    push, iss;
        mreq_t r;
        push = fm_req_valid && (m_req.size() < 4) && (fm_req_opcode == 2'b01 || fm_req_opcode == 2'b11);
        iss  = (m_req.size() > 0) && (m_req[0].wr || m_tag.size() < 8) && mem_req_ready;
        if (fm_req_valid && fm_req_opcode == 2'b10) m_err = 1;
        m_rsp_v = 0;
        if (mem_rsp_valid) begin
            if (m_tag.size() > 0) begin
                m_rsp_v    = 1;
                m_rsp_tq   = m_tag.pop_front();
                m_rsp_data = mem_rsp_data;
            end else begin
                m_err = 1;
            end
        end
        if (iss) begin
            r = m_req.pop_front();
            if (!r.wr) m_tag.push_back(r.tq);
        end
        if (push) begin
            r.wr   = (fm_req_opcode == 2'b01);
            r.tq   = fm_req_tq_id;
            r.cl   = fm_req_address[19:4];
            r.data = r.wr ? fm_req_data : 128'h0;
            m_req.push_back(r);
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_req(input bit v, input bit [2:0] tq, input bit [19:0] addr,
                           input bit [127:0] d, input bit [1:0] opc);
        fm_req_valid   = v;
        fm_req_tq_id   = tq;
        fm_req_address = addr;
        fm_req_data    = d;
        fm_req_opcode  = opc;
    endtask

    task automatic apply_reset();
        set_req(0, 0, 0, 0, 0);
        mem_req_ready = 0;
        mem_rsp_valid = 0;
        mem_rsp_data  = 0;
        rst_n = 0;
        repeat (2) @(negedge clk);
        rst_n = 1;
        model_clear();
    endtask

    task automatic test_reset();
        apply_reset();
        n_tests++;
        if ({fm_req_ready, mem_req_valid, fm_rd_rsp_valid, err_sticky} !== 4'b1000) begin
            n_fail++;
            $display("FAIL reset_flags got rdy/vld/rsp/err=%b want 1000",
                     {fm_req_ready, mem_req_valid, fm_rd_rsp_valid, err_sticky});
        end
        n_tests++;
        if (outstanding_cnt !== 4'd0 || fm_rd_rsp_tq_id !== 3'd0 || fm_rd_rsp_data !== 128'h0) begin
            n_fail++;
            $display("FAIL reset_vals got cnt=%0d tq=%0d data=%h want 0", outstanding_cnt,
                     fm_rd_rsp_tq_id, fm_rd_rsp_data);
        end
    endtask

    task automatic test_single_fill();
        apply_reset();
        mem_req_ready = 1;
        set_req(1, 3'd5, 20'h12340, 0, 2'b11);
        tick();
        set_req(0, 0, 0, 0, 0);
        n_tests++;
        if (mem_req_valid !== 1'b1 || mem_req_wr !== 1'b0 || mem_req_cl_addr !== 16'h1234 ||
            outstanding_cnt !== 4'd0) begin
            n_fail++;
            $display("FAIL fill_issue got v=%b wr=%b cl=%h cnt=%0d want 1 0 1234 0", mem_req_valid,
                     mem_req_wr, mem_req_cl_addr, outstanding_cnt);
        end
        tick();
        n_tests++;
        if (outstanding_cnt !== 4'd1 || mem_req_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL fill_outstanding got cnt=%0d v=%b want 1 0", outstanding_cnt, mem_req_valid);
        end
        tick();
        mem_rsp_valid = 1;
        mem_rsp_data  = {16{8'hA5}};
        tick();
        mem_rsp_valid = 0;
        n_tests++;
        if (fm_rd_rsp_valid !== 1'b1 || fm_rd_rsp_tq_id !== 3'd5 || fm_rd_rsp_data !== {16{8'hA5}} ||
            outstanding_cnt !== 4'd0) begin
            n_fail++;
            $display("FAIL fill_rsp got v=%b tq=%0d data=%h cnt=%0d want 1 5 a5.. 0", fm_rd_rsp_valid,
                     fm_rd_rsp_tq_id, fm_rd_rsp_data, outstanding_cnt);
        end
        tick();
        n_tests++;
        if (fm_rd_rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL fill_rsp_pulse got v=%b want 0", fm_rd_rsp_valid);
        end
    endtask

    task automatic test_evict_then_fill();
        apply_reset();
        mem_req_ready = 1;
        set_req(1, 3'd1, 20'h00010, 128'hDEAD, 2'b01);
        tick();
        n_tests++;
        if (mem_req_valid !== 1'b1 || mem_req_wr !== 1'b1 || mem_req_cl_addr !== 16'h0001 ||
            mem_req_wdata !== 128'hDEAD) begin
            n_fail++;
            $display("FAIL evict_issue got v=%b wr=%b cl=%h wd=%h want 1 1 0001 dead", mem_req_valid,
                     mem_req_wr, mem_req_cl_addr, mem_req_wdata);
        end
        set_req(1, 3'd2, 20'h00020, 128'h5555, 2'b11);
        tick();
        set_req(0, 0, 0, 0, 0);
        n_tests++;
        if (mem_req_valid !== 1'b1 || mem_req_wr !== 1'b0 || mem_req_cl_addr !== 16'h0002 ||
            mem_req_wdata !== 128'h0 || fm_rd_rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL evict_fill_issue got v=%b wr=%b cl=%h wd=%h rsp=%b want 1 0 0002 0 0",
                     mem_req_valid, mem_req_wr, mem_req_cl_addr, mem_req_wdata, fm_rd_rsp_valid);
        end
        tick();
        n_tests++;
        if (outstanding_cnt !== 4'd1 || fm_rd_rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL evict_no_rsp got cnt=%0d rsp=%b want 1 0", outstanding_cnt, fm_rd_rsp_valid);
        end
        mem_rsp_valid = 1;
        mem_rsp_data  = 128'h0123456789ABCDEF;
        tick();
        mem_rsp_valid = 0;
        n_tests++;
        if (fm_rd_rsp_valid !== 1'b1 || fm_rd_rsp_tq_id !== 3'd2 || outstanding_cnt !== 4'd0) begin
            n_fail++;
            $display("FAIL evict_fill_rsp got v=%b tq=%0d cnt=%0d want 1 2 0", fm_rd_rsp_valid,
                     fm_rd_rsp_tq_id, outstanding_cnt);
        end
    endtask

    task automatic test_backpressure();
        bit exp_rdy;
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            exp_rdy = (i < 4);
            n_tests++;
            if (fm_req_ready !== exp_rdy) begin
                n_fail++;
                $display("FAIL bp_ready i=%0d got %b want %b", i, fm_req_ready, exp_rdy);
            end
            if (i > 0) begin
                n_tests++;
                if (mem_req_valid !== 1'b1 || mem_req_cl_addr !== 16'h0100 || mem_req_wdata !== 128'd1) begin
                    n_fail++;
                    $display("FAIL bp_stable i=%0d got v=%b cl=%h wd=%h want 1 0100 1", i, mem_req_valid,
                             mem_req_cl_addr, mem_req_wdata);
                end
            end
            set_req(1, 3'(i), {16'(16'h0100 + i), 4'h0}, 128'(i + 1), 2'b01);
            tick();
        end
        mem_req_ready = 1;
        tick();
        n_tests++;
        if (fm_req_ready !== 1'b1 || mem_req_cl_addr !== 16'h0101) begin
            n_fail++;
            $display("FAIL bp_no_bypass got rdy=%b cl=%h want 1 0101", fm_req_ready, mem_req_cl_addr);
        end
        tick();
        set_req(0, 0, 0, 0, 0);
        for (int k = 2; k < 5; k++) begin
            n_tests++;
            if (mem_req_valid !== 1'b1 || mem_req_cl_addr !== 16'(16'h0100 + k) ||
                mem_req_wdata !== 128'(k + 1)) begin
                n_fail++;
                $display("FAIL bp_order k=%0d got v=%b cl=%h wd=%h want 1 %h %0d", k, mem_req_valid,
                         mem_req_cl_addr, mem_req_wdata, 16'(16'h0100 + k), k + 1);
            end
            tick();
        end
        n_tests++;
        if (mem_req_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_drain got v=%b want 0", mem_req_valid);
        end
    endtask

    task automatic test_tag_full();
        apply_reset();
        mem_req_ready = 1;
        for (int i = 0; i < 8; i++) begin
            set_req(1, 3'(i), {16'(16'h0200 + i), 4'h0}, 0, 2'b11);
            tick();
        end
        set_req(1, 3'd0, 20'h03000, 0, 2'b11);
        tick();
        set_req(1, 3'd6, 20'h03010, 128'hBEEF, 2'b01);
        tick();
        set_req(0, 0, 0, 0, 0);
        tick();
        n_tests++;
        if (outstanding_cnt !== 4'd8 || mem_req_valid !== 1'b0 || fm_req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL tag_full_block got cnt=%0d v=%b rdy=%b want 8 0 1", outstanding_cnt,
                     mem_req_valid, fm_req_ready);
        end
        mem_rsp_valid = 1;
        mem_rsp_data  = 128'h1111;
        tick();
        mem_rsp_valid = 0;
        n_tests++;
        if (fm_rd_rsp_valid !== 1'b1 || fm_rd_rsp_tq_id !== 3'd0 || mem_req_valid !== 1'b1 ||
            mem_req_wr !== 1'b0 || mem_req_cl_addr !== 16'h0300 || outstanding_cnt !== 4'd7) begin
            n_fail++;
            $display("FAIL tag_unblock got rsp=%b tq=%0d v=%b wr=%b cl=%h cnt=%0d want 1 0 1 0 0300 7",
                     fm_rd_rsp_valid, fm_rd_rsp_tq_id, mem_req_valid, mem_req_wr, mem_req_cl_addr,
                     outstanding_cnt);
        end
        tick();
        n_tests++;
        if (outstanding_cnt !== 4'd8 || mem_req_valid !== 1'b1 || mem_req_wr !== 1'b1 ||
            mem_req_cl_addr !== 16'h0301 || mem_req_wdata !== 128'hBEEF) begin
            n_fail++;
            $display("FAIL tag_evict_next got cnt=%0d v=%b wr=%b cl=%h wd=%h want 8 1 1 0301 beef",
                     outstanding_cnt, mem_req_valid, mem_req_wr, mem_req_cl_addr, mem_req_wdata);
        end
    endtask

    task automatic test_errors();
        apply_reset();
        mem_req_ready = 1;
        set_req(1, 3'd3, 20'h00500, 0, 2'b10);
        tick();
        set_req(0, 0, 0, 0, 0);
        tick();
        n_tests++;
        if (err_sticky !== 1'b1 || mem_req_valid !== 1'b0 || fm_req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL err_opcode got err=%b v=%b rdy=%b want 1 0 1", err_sticky, mem_req_valid,
                     fm_req_ready);
        end
        apply_reset();
        mem_rsp_valid = 1;
        mem_rsp_data  = 128'h77;
        tick();
        mem_rsp_valid = 0;
        tick();
        n_tests++;
        if (err_sticky !== 1'b1 || fm_rd_rsp_valid !== 1'b0 || outstanding_cnt !== 4'd0) begin
            n_fail++;
            $display("FAIL err_orphan got err=%b rsp=%b cnt=%0d want 1 0 0", err_sticky,
                     fm_rd_rsp_valid, outstanding_cnt);
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        mem_req_ready = 1;
        set_req(1, 3'd1, 20'h00100, 0, 2'b11);
        tick();
        set_req(1, 3'd2, 20'h00110, 0, 2'b11);
        tick();
        set_req(1, 3'd3, 20'h00120, 128'h3, 2'b01);
        tick();
        mem_req_ready = 0;
        set_req(1, 3'd4, 20'h00130, 128'h4, 2'b01);
        tick();
        set_req(1, 3'd5, 20'h00140, 128'h5, 2'b01);
        tick();
        set_req(0, 0, 0, 0, 0);
        n_tests++;
        if (outstanding_cnt !== 4'd2 || mem_req_valid !== 1'b1 || fm_req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_setup got cnt=%0d v=%b rdy=%b want 2 1 1", outstanding_cnt,
                     mem_req_valid, fm_req_ready);
        end
        #2 rst_n = 0;
        #1;
        n_tests++;
        if (outstanding_cnt !== 4'd0 || mem_req_valid !== 1'b0 || fm_req_ready !== 1'b1 ||
            err_sticky !== 1'b0 || fm_rd_rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_async_reset got cnt=%0d v=%b rdy=%b err=%b rsp=%b want 0 0 1 0 0",
                     outstanding_cnt, mem_req_valid, fm_req_ready, err_sticky, fm_rd_rsp_valid);
        end
        @(negedge clk);
        rst_n = 1;
        mem_rsp_valid = 1;
        mem_rsp_data  = 128'hAB;
        tick();
        mem_rsp_valid = 0;
        n_tests++;
        if (err_sticky !== 1'b1 || fm_rd_rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_stale_rsp got err=%b rsp=%b want 1 0", err_sticky, fm_rd_rsp_valid);
        end
    endtask

    task automatic test_random();
        bit exp_v;
        apply_reset();
        for (int c = 0; c < 600; c++) begin
            exp_v = (m_req.size() > 0) && (m_req[0].wr || m_tag.size() < 8);
            n_tests++;
            if (fm_req_ready !== (m_req.size() < 4) || mem_req_valid !== exp_v) begin
                n_fail++;
                $display("FAIL rnd_flow cyc=%0d got rdy=%b v=%b want %b %b", c, fm_req_ready,
                         mem_req_valid, (m_req.size() < 4), exp_v);
            end
            if (exp_v) begin
                n_tests++;
                if (mem_req_wr !== m_req[0].wr || mem_req_cl_addr !== m_req[0].cl ||
                    mem_req_wdata !== m_req[0].data) begin
                    n_fail++;
                    $display("FAIL rnd_req cyc=%0d got wr=%b cl=%h wd=%h want %b %h %h", c, mem_req_wr,
                             mem_req_cl_addr, mem_req_wdata, m_req[0].wr, m_req[0].cl, m_req[0].data);
                end
            end
            n_tests++;
            if (outstanding_cnt !== 4'(m_tag.size()) || fm_rd_rsp_valid !== m_rsp_v ||
                err_sticky !== m_err) begin
                n_fail++;
                $display("FAIL rnd_state cyc=%0d got cnt=%0d rsp=%b err=%b want %0d %b %b", c,
                         outstanding_cnt, fm_rd_rsp_valid, err_sticky, m_tag.size(), m_rsp_v, m_err);
            end
            if (m_rsp_v) begin
                n_tests++;
                if (fm_rd_rsp_tq_id !== m_rsp_tq || fm_rd_rsp_data !== m_rsp_data) begin
                    n_fail++;
                    $display("FAIL rnd_rsp cyc=%0d got tq=%0d data=%h want %0d %h", c, fm_rd_rsp_tq_id,
                             fm_rd_rsp_data, m_rsp_tq, m_rsp_data);
                end
            end
            fm_req_valid   = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 4))
                0:       fm_req_opcode = 2'b00;
                1, 2:    fm_req_opcode = 2'b01;
                default: fm_req_opcode = 2'b11;
            endcase
            fm_req_tq_id   = 3'($urandom());
            fm_req_address = 20'($urandom());
            fm_req_data    = {$urandom(), $urandom(), $urandom(), $urandom()};
            mem_req_ready  = ($urandom_range(0, 3) != 0);
            mem_rsp_valid  = (m_tag.size() > 0) && ($urandom_range(0, 2) == 0);
            mem_rsp_data   = {$urandom(), $urandom(), $urandom(), $urandom()};
            model_edge();
            tick();
        end
        set_req(0, 0, 0, 0, 0);
        mem_rsp_valid = 0;
    endtask

    initial begin
        test_reset();
        test_single_fill();
        test_evict_then_fill();
        test_backpressure();
        test_tag_full();
        test_errors();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog run did not complete, tests=%0d failed=%0d", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
